// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg: FSM state encoding and default parameter values shared by
// the register sequencer and anything that instantiates it.
package i2c_reg_pkg;

    // Default parameter values.
    localparam int AW_DEF     = 6;  // register address width
    localparam int DW_DEF     = 8;  // register data width
    localparam int LW_DEF     = 4;  // burst-length field width
    localparam int RD_LAT_DEF = 1;  // rd strobe to valid read data, 1..15
    localparam int GAP_DEF    = 0;  // idle cycles between beats

    // Width of the shared RDWAIT/GAP down-counter; holds RD_LAT-1 (<= 14)
    // and GAP-1, so GAP is usable up to 256.
    localparam int WAIT_W = 8;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_RDWAIT = 3'd3;
    localparam logic [2:0] ST_RSP    = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

endpackage

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns a burst command (read or write, optional address
// auto-increment, 1..2^LW beats) into single-cycle register strobes, and
// returns one response per read beat or one acknowledge per write burst.
// Every output is a flop; the FSM decides the next state combinationally
// and the output flops are loaded from that decision.
module i2c_reg_seq
    import i2c_reg_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int LW     = LW_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int GAP    = GAP_DEF
) (
    input  logic          i_sysclk,
    input  logic          i_reset,
    // command channel
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_write,
    input  logic          i_cmd_inc,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [LW-1:0] i_cmd_len,
    // write-data channel
    input  logic          i_wd_valid,
    output logic          o_wd_ready,
    input  logic [DW-1:0] i_wd_data,
    // register file port
    output logic          o_wr_ena,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_rd_ena,
    output logic [AW-1:0] o_rd_addr,
    input  logic [DW-1:0] i_rd_data,
    // response channel
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_last
);

    // Latched command and progress counters.
    logic [2:0]        r_state;
    logic              r_write;
    logic              r_inc;
    logic [AW-1:0]     r_addr;        // address of the current beat
    logic [LW-1:0]     r_beats_left;  // beats remaining after the current one
    logic [WAIT_W-1:0] r_wait;        // RDWAIT / GAP down-counter

    // Next-state decision and beat bookkeeping.
    logic [2:0]    w_state_nxt;
    logic          w_final;
    logic          w_accept;
    logic          w_next_beat;
    logic          w_beat_write;
    logic [AW-1:0] w_beat_addr;

    assign w_final      = (r_beats_left == '0);
    assign w_accept     = (r_state == ST_IDLE) && i_cmd_valid;
    // Entering SETUP from anywhere other than IDLE/SETUP starts a follow-on beat.
    assign w_next_beat  = (w_state_nxt == ST_SETUP) && (r_state != ST_SETUP)
                          && (r_state != ST_IDLE);
    assign w_beat_write = w_accept ? i_cmd_write : r_write;
    // Address arithmetic is AW bits wide, so 0x3F + 1 wraps to 0x00.
    assign w_beat_addr  = w_accept ? i_cmd_addr
                                   : (r_inc ? r_addr + AW'(1) : r_addr);

    // Next-state logic for the beat sequencer.
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // w_state_nxt, so no latch is inferred for unlisted conditions.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                // Reads spend one cycle here; writes wait for a data beat.
                if (!r_write || i_wd_valid) w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                if (!r_write)     w_state_nxt = ST_RDWAIT;
                else if (w_final) w_state_nxt = ST_RSP;
                else if (GAP == 0) w_state_nxt = ST_SETUP;
                else              w_state_nxt = ST_GAP;
            end
            ST_RDWAIT: begin
                if (r_wait == '0) w_state_nxt = ST_RSP;
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    if (w_final)       w_state_nxt = ST_IDLE;
                    else if (GAP == 0) w_state_nxt = ST_SETUP;
                    else               w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_wait == '0) w_state_nxt = ST_SETUP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latched command, beat/wait counters and strobe/handshake flops.
    always_ff @(posedge i_sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_inc        <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_wait       <= '0;
            o_cmd_ready  <= 1'b1;
            o_wd_ready   <= 1'b0;
            o_wr_ena     <= 1'b0;
            o_rd_ena     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            o_cmd_ready <= (w_state_nxt == ST_IDLE);
            o_wd_ready  <= (w_state_nxt == ST_SETUP) && w_beat_write;
            o_wr_ena    <= (w_state_nxt == ST_STROBE) && r_write;
            o_rd_ena    <= (w_state_nxt == ST_STROBE) && !r_write;

            if (w_accept) begin
                r_write      <= i_cmd_write;
                r_inc        <= i_cmd_inc;
                r_beats_left <= i_cmd_len;
            end else if (w_next_beat) begin
                r_beats_left <= r_beats_left - LW'(1);
            end

            if (w_accept || w_next_beat) begin
                r_addr <= w_beat_addr;
            end

            // Load the RDWAIT or GAP length on entry, then count down to 0.
            if (r_state == ST_STROBE && w_state_nxt == ST_RDWAIT) begin
                r_wait <= WAIT_W'(RD_LAT - 1);
            end else if (w_state_nxt == ST_GAP && r_state != ST_GAP) begin
                r_wait <= WAIT_W'(GAP - 1);
            end else if (r_wait != '0) begin
                r_wait <= r_wait - WAIT_W'(1);
            end
        end
    end

    // Register-port address/data and response channel flops.
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_rd_addr   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_last  <= 1'b0;
        end else begin
            // The beat address is presented on entry to SETUP and then held
            // untouched through STROBE.
            if (w_accept || w_next_beat) begin
                if (w_beat_write) o_wr_addr <= w_beat_addr;
                else              o_rd_addr <= w_beat_addr;
            end

            if (r_state == ST_SETUP && r_write && i_wd_valid) begin
                o_wr_data <= i_wd_data;
            end

            if (r_state == ST_RDWAIT && w_state_nxt == ST_RSP) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= i_rd_data;
                o_rsp_last  <= w_final;
            end else if (r_state == ST_STROBE && w_state_nxt == ST_RSP) begin
                // Write acknowledge: only issued after the final beat.
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= '0;
                o_rsp_last  <= 1'b1;
            end else if (r_state == ST_RSP && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
                o_rsp_last  <= 1'b0;
            end
        end
    end

endmodule
